// File: rtl/cmv300_frame_sequencer_if.sv
// Signal bundle between the capture controller and the CMV300 frame sequencer.
// i_start is a one-cycle request: taken at once in IDLE, otherwise held one-deep until
// the sequencer returns to IDLE. i_fifo_ready is a level, sampled every cycle while waiting.
interface cmv300_frame_sequencer_if;
  logic       i_start;
  logic       i_fifo_ready;
  logic       i_lval_async;
  logic       o_frame_req;
  logic       o_pad_en;
  logic       o_busy;
  logic       o_done;
  logic       o_timeout;
  logic [8:0] o_line_count;
  logic       o_start_pending;
  logic [2:0] dbg_state;

  modport master (
    output i_start, i_fifo_ready, i_lval_async,
    input  o_frame_req, o_pad_en, o_busy, o_done, o_timeout, o_line_count, o_start_pending,
    input  dbg_state
  );

  modport slave (
    input  i_start, i_fifo_ready, i_lval_async,
    output o_frame_req, o_pad_en, o_busy, o_done, o_timeout, o_line_count, o_start_pending,
    output dbg_state
  );
endinterface

// File: rtl/cmv300_frame_sequencer.sv
// One-capture-per-request frame sequencer for the CMV300 path, entirely in the i_clk domain.
// Lines are counted from synchronised LVAL falling edges; a single 24-bit timer guards every wait.
module cmv300_frame_sequencer #(
  parameter int          LINES_PER_FRAME  = 488,
  parameter int          FRAME_REQ_CYCLES = 4,
  parameter int          PAD_CYCLES       = 192,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd4000000,
  parameter int          SYNC_STAGES      = 2
) (
  input logic i_clk,
  input logic line_counter_rst,
  cmv300_frame_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FIFO = 3'd1,
    REQ       = 3'd2,
    ACTIVE    = 3'd3,
    PAD       = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [23:0] REQ_LAST = 24'(FRAME_REQ_CYCLES - 1);
  localparam logic [23:0] PAD_LAST = 24'(PAD_CYCLES - 1);
  localparam logic [23:0] TO_LAST  = TIMEOUT_CYCLES - 24'd1;
  localparam logic [8:0]  LINES    = 9'(LINES_PER_FRAME);

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lval_prev;
  logic                   line_end;
  logic [23:0]            timer;
  logic [8:0]             line_count;
  logic                   pending;
  logic                   timeout_q;
  logic                   timer_expired;
  logic                   line_accept;
  logic                   count_clear;
  logic                   fire_timeout;

  always_ff @(posedge i_clk or posedge line_counter_rst) begin
    if (line_counter_rst) begin
      sync      <= '0;
      lval_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], bus.i_lval_async};
      lval_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign line_end = lval_prev & ~sync[SYNC_STAGES-1];

  always_comb begin
    state_n       = state;
    timer_expired = (timer == TO_LAST);
    line_accept   = 1'b0;
    count_clear   = 1'b0;
    fire_timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start || pending) state_n = WAIT_FIFO;
      end
      WAIT_FIFO: begin
        if (timer_expired) begin
          fire_timeout = 1'b1;
          state_n      = IDLE;
        end else if (bus.i_fifo_ready) begin
          count_clear = 1'b1;
          state_n     = REQ;
        end
      end
      REQ: begin
        if (timer_expired) begin
          fire_timeout = 1'b1;
          state_n      = IDLE;
        end else if (timer == REQ_LAST) begin
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        // A line edge landing on the expiry cycle still counts and reloads the timer.
        if (line_end) begin
          line_accept = 1'b1;
          if (line_count >= LINES - 9'd1) state_n = PAD;
        end else if (timer_expired) begin
          fire_timeout = 1'b1;
          state_n      = IDLE;
        end
      end
      PAD: begin
        if (timer == PAD_LAST) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge line_counter_rst) begin
    if (line_counter_rst) begin
      state      <= IDLE;
      timer      <= '0;
      line_count <= '0;
      pending    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state     <= state_n;
      timeout_q <= fire_timeout;
      if (state_n != state || line_accept) timer <= '0;
      else                                 timer <= timer + 24'd1;
      if (count_clear)                                 line_count <= '0;
      else if (line_accept && line_count < LINES)      line_count <= line_count + 9'd1;
      // A start arriving while busy (including the DONE cycle) waits for the next IDLE.
      if (state == IDLE && (bus.i_start || pending))   pending <= 1'b0;
      else if (bus.i_start)                            pending <= 1'b1;
    end
  end

  assign bus.o_frame_req     = (state == REQ);
  assign bus.o_pad_en        = (state == PAD);
  assign bus.o_busy          = (state != IDLE);
  assign bus.o_done          = (state == DONE);
  assign bus.o_timeout       = timeout_q;
  assign bus.o_line_count    = line_count;
  assign bus.o_start_pending = pending;
  assign bus.dbg_state       = state;
endmodule

// File: tb/tb_cmv300_frame_sequencer.sv
// Randomised bench for cmv300_frame_sequencer: frame outcomes predicted from LVAL gap lists,
// pulse widths and timeout spacing checked by an independent monitor.
module tb_cmv300_frame_sequencer;
  localparam int LPF = 488;
  localparam int FRC = 4;
  localparam int PADC = 192;
  localparam int TO = 400;
  localparam int W = 10;

  logic clk;
  logic line_counter_rst;
  cmv300_frame_sequencer_if bus();

  cmv300_frame_sequencer #(
    .LINES_PER_FRAME (LPF),
    .FRAME_REQ_CYCLES(FRC),
    .PAD_CYCLES      (PADC),
    .TIMEOUT_CYCLES  (24'(TO)),
    .SYNC_STAGES     (2)
  ) dut (
    .i_clk           (clk),
    .line_counter_rst(line_counter_rst),
    .bus             (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int end_cnt = 0;
  int last_count = 0;
  int gaps_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // A frame ends done when LPF edges arrive with no gap longer than TO; otherwise it
  // times out holding the number of lines accepted before the silence.
  function automatic logic [W-1:0] model_frame();
    int cnt = 0;
    foreach (gaps_q[i]) begin
      if (gaps_q[i] > TO) break;
      cnt++;
      if (cnt == LPF) break;
    end
    last_count = cnt;
    return {(cnt == LPF) ? 1'b1 : 1'b0, 9'(cnt)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int fr_w = 0, pad_w = 0;
  int last_chg = 0, busy_rise = 0;
  int prev_cnt = 0;
  logic prev_busy = 1'b0, fr_seen = 1'b0, check_idle = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (line_counter_rst) begin
      fr_w = 0;
      pad_w = 0;
      fr_seen = 1'b0;
      prev_busy = 1'b0;
      check_idle = 1'b0;
      prev_cnt = 0;
    end else begin
      if (int'(bus.o_line_count) != prev_cnt) last_chg = cyc;
      prev_cnt = int'(bus.o_line_count);
      if (bus.o_busy && !prev_busy) begin
        busy_rise = cyc;
        fr_seen = 1'b0;
      end
      prev_busy = bus.o_busy;
      if (bus.o_frame_req) begin
        fr_w++;
        fr_seen = 1'b1;
      end else if (fr_w != 0) begin
        check("frame_req_width", fr_w, FRC);
        fr_w = 0;
      end
      if (bus.o_pad_en) pad_w++;
      else if (pad_w != 0) begin
        check("pad_en_width", pad_w, PADC);
        pad_w = 0;
      end
      if (check_idle) begin
        check("busy_after_done", int'(bus.o_busy), 0);
        check_idle = 1'b0;
      end
      if (bus.o_done || bus.o_timeout) begin
        if (exp_q.size() == 0) bound_fail("unexpected_frame_end");
        else check("frame_result", int'({bus.o_done, bus.o_line_count}), int'(exp_q.pop_front()));
        if (bus.o_done) check_idle = 1'b1;
        if (bus.o_timeout) begin
          check("busy_at_timeout", int'(bus.o_busy), 0);
          check("timeout_spacing", cyc - (fr_seen ? last_chg : busy_rise), TO);
        end
        end_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic fill_gaps(input int n, input int lo, input int hi);
    gaps_q.delete();
    for (int i = 0; i < n; i++) gaps_q.push_back(int'($urandom_range(hi, lo)));
  endtask

  task automatic wait_fr(input logic level, input string name);
    int n = 0;
    while (bus.o_frame_req !== level && n < 3000) begin
      tick();
      n++;
    end
    if (bus.o_frame_req !== level) bound_fail(name);
  endtask

  task automatic wait_end(input int target);
    int n = 0;
    while (end_cnt < target && n < 6000) begin
      tick();
      n++;
    end
    if (end_cnt < target) bound_fail("frame_end_wait");
  endtask

  // Falling LVAL edges are spaced exactly gaps_q[i] cycles apart.
  task automatic drive_lines(input int sa, input int sb);
    for (int i = 0; i < gaps_q.size(); i++) begin
      for (int c = 0; c < gaps_q[i]; c++) begin
        bus.i_lval_async = (c < gaps_q[i] - 2);
        bus.i_start = ((i == sa) || (i == sb)) && (c == 0);
        tick();
        if (i == sa && c == 0) check("start_pending_set", int'(bus.o_start_pending), 1);
      end
    end
    bus.i_lval_async = 1'b0;
    bus.i_start = 1'b0;
  endtask

  task automatic run_frame(input int sa, input int sb);
    exp_q.push_back(model_frame());
    wait_fr(1'b1, "frame_req_rise");
    wait_fr(1'b0, "frame_req_fall");
    drive_lines(sa, sb);
  endtask

  initial begin
    int viol;
    int n;
    line_counter_rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_fifo_ready = 1'b0;
    bus.i_lval_async = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_frame_req", int'(bus.o_frame_req), 0);
    check("rst_pad_en", int'(bus.o_pad_en), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_timeout", int'(bus.o_timeout), 0);
    check("rst_line_count", int'(bus.o_line_count), 0);
    check("rst_pending", int'(bus.o_start_pending), 0);
    line_counter_rst = 1'b0;
    bus.i_fifo_ready = 1'b1;
    repeat (2) tick();

    // normal frame
    fill_gaps(LPF, 3, 8);
    pulse_start();
    run_frame(-1, -1);
    wait_end(1);

    // gaps at exactly TO and TO-1: both lines must count
    fill_gaps(LPF, 3, 8);
    gaps_q[$urandom_range(470, 10)] = TO;
    gaps_q[$urandom_range(470, 10)] = TO - 1;
    pulse_start();
    run_frame(-1, -1);
    wait_end(2);

    // LVAL stops after 200 lines
    fill_gaps(200, 3, 8);
    pulse_start();
    run_frame(-1, -1);
    wait_end(3);

    // gap one cycle too long after 50 lines
    fill_gaps(50, 3, 8);
    gaps_q.push_back(TO + 1);
    pulse_start();
    run_frame(-1, -1);
    wait_end(4);

    // FIFO stall for 100 cycles, then a full frame
    bus.i_fifo_ready = 1'b0;
    fill_gaps(LPF, 3, 8);
    pulse_start();
    viol = 0;
    repeat (100) begin
      tick();
      if (bus.o_frame_req) viol++;
    end
    check("stall_no_frame_req", viol, 0);
    check("stall_busy", int'(bus.o_busy), 1);
    bus.i_fifo_ready = 1'b1;
    check("req_not_same_cycle_as_ready", int'(bus.o_frame_req), 0);
    tick();
    check("req_after_ready", int'(bus.o_frame_req), 1);
    run_frame(-1, -1);
    wait_end(5);

    // FIFO never ready: timeout in WAIT_FIFO, count held from last frame
    bus.i_fifo_ready = 1'b0;
    exp_q.push_back({1'b0, 9'(last_count)});
    pulse_start();
    viol = 0;
    repeat (TO + 5) begin
      tick();
      if (bus.o_frame_req) viol++;
    end
    check("wait_timeout_no_frame_req", viol, 0);
    wait_end(6);
    bus.i_fifo_ready = 1'b1;
    tick();

    // two starts during one frame: one queued, one dropped
    fill_gaps(LPF, 3, 8);
    pulse_start();
    run_frame(100, 150);
    wait_end(7);
    n = 0;
    while (!bus.o_frame_req && n < 10) begin
      tick();
      n++;
    end
    check("requeue_within_3", int'(n <= 3), 1);
    fill_gaps(LPF, 3, 8);
    run_frame(-1, -1);
    wait_end(8);
    repeat (30) tick();
    check("no_third_frame_busy", int'(bus.o_busy), 0);
    check("no_third_frame_pending", int'(bus.o_start_pending), 0);
    check("no_third_frame_ends", end_cnt, 8);

    // asynchronous reset 50 cycles into PAD
    fill_gaps(LPF, 3, 8);
    pulse_start();
    run_frame(-1, -1);
    n = 0;
    while (!bus.o_pad_en && n < 200) begin
      tick();
      n++;
    end
    if (!bus.o_pad_en) bound_fail("pad_en_rise");
    repeat (49) tick();
    #2 line_counter_rst = 1'b1;
    #1;
    check("async_rst_pad_en", int'(bus.o_pad_en), 0);
    check("async_rst_busy", int'(bus.o_busy), 0);
    check("async_rst_line_count", int'(bus.o_line_count), 0);
    exp_q.delete();
    last_count = 0;
    repeat (2) tick();
    line_counter_rst = 1'b0;
    tick();
    fill_gaps(LPF, 3, 8);
    pulse_start();
    run_frame(-1, -1);
    wait_end(9);
    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
